// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared types and helpers for the sequential magnitude comparator.
//   state_e      : controller states (IDLE, RUN, DONE)
//   result_e     : 2-bit compare outcome (EQ, GT, LT)
//   num_slices() : number of DIGIT-wide slices in a WIDTH-bit operand
//   idx_width()  : width of the slice index counter, clog2(N) with a floor of 1
//   flags_of()   : result code -> one-hot {gt, lt, eq} flag vector
// ---------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EQ = 2'd0,
        GT = 2'd1,
        LT = 2'd2
    } result_e;

    // Guarded against an illegal DIGIT so that the elaboration-time
    // legality check gets to report the problem instead of a divide by zero.
    function automatic int num_slices(input int width, input int digit);
        if (digit < 1) begin
            return 1;
        end
        return width / digit;
    endfunction

    // A one-slice compare still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // Flag vector ordering is {gt, lt, eq}.
    function automatic logic [2:0] flags_of(input result_e res);
        case (res)
            GT:      return 3'b100;
            LT:      return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/digit_compare.sv
// ---------------------------------------------------------------------------
// digit_compare
// Combinational unsigned magnitude compare of two DIGIT-bit slices. This is
// the old fixed 4-bit comparator widened to any slice size.
// Ports:
//   a, b : slice operands (unsigned)
//   gt   : a >  b
//   lt   : a <  b
//   eq   : a == b
// Exactly one output is high for any input pair.
// ---------------------------------------------------------------------------
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
// Multi-cycle magnitude comparator for wide operands. The operands are
// latched on an accepted start and compared one DIGIT-bit slice per clock,
// most significant slice first, so only a DIGIT-wide comparator sits in the
// timing path.
//
// Handshake: start is honoured only while IDLE (busy = 0, done = 0); there
// is no queuing, a start seen in RUN or DONE is dropped. An accepted start
// clears all result flags. busy is high for every RUN cycle, done is a
// one-cycle pulse in the cycle after the deciding edge, and the flags are
// valid from that pulse until the next accepted start.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : compare request
//   signed_mode   : 1 = two's-complement compare (sampled with start)
//   a, b          : operands (sampled with start)
//   busy          : high while comparing
//   done          : one-cycle completion pulse
//   a_gt_b/a_lt_b/a_eq_b : registered one-hot result
//   dbg_state     : current controller state, for observation only
// ---------------------------------------------------------------------------
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output state_e           dbg_state
);

    localparam int N  = num_slices(WIDTH, DIGIT);
    localparam int IW = idx_width(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    // -----------------------------------------------------------------------
    // Parameter legality
    // -----------------------------------------------------------------------
    generate
        if (DIGIT < 1) begin : g_bad_digit
            $error("seq_magnitude_comparator: DIGIT must be >= 1");
        end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
            $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_e           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    result_e          r_first;   // first differing slice seen so far (sticky)
    logic [2:0]       r_flags;   // {gt, lt, eq}
    logic             r_busy;
    logic             r_done;

    // -----------------------------------------------------------------------
    // Next-state / datapath wires
    // -----------------------------------------------------------------------
    state_e           w_nxt_state;
    logic [IW-1:0]    w_nxt_idx;
    logic [WIDTH-1:0] w_nxt_a;
    logic [WIDTH-1:0] w_nxt_b;
    result_e          w_nxt_first;
    logic [2:0]       w_nxt_flags;

    logic [DIGIT-1:0] w_slice_a;
    logic [DIGIT-1:0] w_slice_b;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;
    result_e          w_slice_res;
    result_e          w_eff_res;

    // -----------------------------------------------------------------------
    // Slice select: idx 0 picks the most significant slice.
    // -----------------------------------------------------------------------
    always_comb begin
        w_slice_a = '0;
        w_slice_b = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IW'(k)) begin
                w_slice_a = r_a[WIDTH-1-k*DIGIT -: DIGIT];
                w_slice_b = r_b[WIDTH-1-k*DIGIT -: DIGIT];
            end
        end
    end

    digit_compare #(
        .DIGIT (DIGIT)
    ) u_digit_compare (
        .a  (w_slice_a),
        .b  (w_slice_b),
        .gt (w_gt),
        .lt (w_lt),
        .eq (w_eq)
    );

    always_comb begin
        case ({w_gt, w_lt, w_eq})
            3'b100:  w_slice_res = GT;
            3'b010:  w_slice_res = LT;
            default: w_slice_res = EQ;
        endcase
    end

    // Once a slice has differed, its verdict wins over anything less
    // significant; only while everything above was equal does the current
    // slice decide.
    assign w_eff_res = (r_first != EQ) ? r_first : w_slice_res;

    // -----------------------------------------------------------------------
    // Controller: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // -----------------------------------------------------------------------
    // Controller: next state and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_a     = r_a;
        w_nxt_b     = r_b;
        w_nxt_first = r_first;
        w_nxt_flags = r_flags;

        case (r_state)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's-complement order onto
                    // unsigned order, so signed_mode needs no storage beyond
                    // this point and the slice datapath stays unsigned.
                    w_nxt_a            = a;
                    w_nxt_b            = b;
                    w_nxt_a[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
                    w_nxt_b[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
                    w_nxt_flags        = 3'b000;
                    w_nxt_first        = EQ;
                    w_nxt_idx          = '0;
                    w_nxt_state        = RUN;
                end
            end

            RUN: begin
                if ((EARLY_EXIT != 0) && (w_slice_res != EQ)) begin
                    w_nxt_flags = flags_of(w_slice_res);
                    w_nxt_state = DONE;
                end else if (r_idx == LAST_IDX) begin
                    w_nxt_flags = flags_of(w_eff_res);
                    w_nxt_state = DONE;
                end else begin
                    w_nxt_first = w_eff_res;
                    w_nxt_idx   = r_idx + IW'(1);
                end
            end

            DONE: begin
                w_nxt_state = IDLE;
            end

            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered status outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_first <= EQ;
            r_flags <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_idx   <= w_nxt_idx;
            r_a     <= w_nxt_a;
            r_b     <= w_nxt_b;
            r_first <= w_nxt_first;
            r_flags <= w_nxt_flags;
            // Decoded from the next state so both are plain flops that track
            // the state register exactly.
            r_busy  <= (w_nxt_state == RUN);
            r_done  <= (w_nxt_state == DONE);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign a_gt_b    = r_flags[2];
    assign a_lt_b    = r_flags[1];
    assign a_eq_b    = r_flags[0];
    assign dbg_state = r_state;

`ifndef SYNTHESIS
    a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_busy && r_done));
    a_result_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        r_done |-> $onehot(r_flags));
    a_busy_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
        r_busy == (r_state == RUN));
`endif

endmodule
